incr_seq_checker: RTL and testbench



---
 rtl/incr_seq_checker.sv | 113 +++++++++++
 tb/tb_incr_seq_checker.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/incr_seq_checker.sv
// Receive-side checker for an incrementing sample stream: locks after LOCK_COUNT
// consecutive +1 steps, then counts matches and flags/counts mismatches.
module incr_seq_checker #(
  parameter int WIDTH      = 4,
  parameter int LOCK_COUNT = 2,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_val,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] good_cnt,
  output logic [WIDTH-1:0] expected
);

  localparam int SW = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam logic [SW-1:0] LC = SW'(LOCK_COUNT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t           r_state;
  logic [SW-1:0]    r_sync_cnt;
  logic             r_locked;
  logic             r_err_pulse;
  logic [CNT_W-1:0] r_err_cnt;
  logic [CNT_W-1:0] r_good_cnt;
  logic [WIDTH-1:0] r_expected;

  logic             w_match;
  logic [SW-1:0]    w_sync_inc;
  logic [WIDTH-1:0] w_next_exp;

  assign w_match    = (in_val == r_expected);
  assign w_sync_inc = r_sync_cnt + 1'b1;
  assign w_next_exp = in_val + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_sync_cnt  <= '0;
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_cnt   <= '0;
      r_good_cnt  <= '0;
      r_expected  <= '0;
    end else if (clear) begin
      // Any sample presented alongside clear is dropped on purpose.
      r_state     <= IDLE;
      r_sync_cnt  <= '0;
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_cnt   <= '0;
      r_good_cnt  <= '0;
      r_expected  <= '0;
    end else begin
      r_err_pulse <= 1'b0;
      if (in_valid) begin
        r_expected <= w_next_exp;
        case (r_state)
          IDLE: begin
            r_state    <= SYNC;
            r_sync_cnt <= '0;
          end
          SYNC: begin
            if (w_match) begin
              if (w_sync_inc == LC) begin
                r_state    <= LOCKED;
                r_locked   <= 1'b1;
                r_sync_cnt <= '0;
              end else begin
                r_sync_cnt <= w_sync_inc;
              end
            end else begin
              r_sync_cnt <= '0;
            end
          end
          LOCKED: begin
            if (w_match) begin
              if (r_good_cnt != '1) r_good_cnt <= r_good_cnt + 1'b1;
            end else begin
              // Mismatch drops lock and reseeds from this sample.
              r_err_pulse <= 1'b1;
              if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
              r_state    <= SYNC;
              r_locked   <= 1'b0;
              r_sync_cnt <= '0;
            end
          end
          default: begin
            r_state    <= IDLE;
            r_locked   <= 1'b0;
            r_sync_cnt <= '0;
          end
        endcase
      end
    end
  end

  assign locked    = r_locked;
  assign err_pulse = r_err_pulse;
  assign err_cnt   = r_err_cnt;
  assign good_cnt  = r_good_cnt;
  assign expected  = r_expected;

endmodule

// File: tb/tb_incr_seq_checker.sv
// Directed bench for incr_seq_checker: two instances (CNT_W=8 and CNT_W=2) share
// stimulus and are compared every cycle against a stream-level model.
module tb_incr_seq_checker;

  localparam int LCNT = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_val;
  logic       clear;

  logic       locked1, pulse1;
  logic [7:0] err1, good1;
  logic [3:0] exp1;
  logic       locked2, pulse2;
  logic [1:0] err2, good2;
  logic [3:0] exp2;

  always #5 clk = ~clk;

  incr_seq_checker #(.WIDTH(4), .LOCK_COUNT(LCNT), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_val(in_val), .clear(clear),
    .locked(locked1), .err_pulse(pulse1), .err_cnt(err1), .good_cnt(good1),
    .expected(exp1)
  );

  incr_seq_checker #(.WIDTH(4), .LOCK_COUNT(LCNT), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_val(in_val), .clear(clear),
    .locked(locked2), .err_pulse(pulse2), .err_cnt(err2), .good_cnt(good2),
    .expected(exp2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Stream-level model: counters kept unbounded, saturation applied on compare.
  bit m_seeded, m_locked, m_pulse;
  int m_streak, m_exp, m_good, m_err;
  bit chk_en = 0;
  bit prev_pulse = 0;
  int pulses_seen = 0;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_seeded = 0; m_locked = 0; m_pulse = 0;
    m_streak = 0; m_exp = 0; m_good = 0; m_err = 0;
  endtask

  task automatic model_apply(input bit v, input int val, input bit c);
    if (c) begin
      model_reset();
    end else begin
      m_pulse = 0;
      if (v) begin
        if (!m_seeded) begin
          m_seeded = 1;
          m_streak = 0;
        end else if (m_locked) begin
          if (val == m_exp) m_good++;
          else begin
            m_pulse = 1; m_err++; m_locked = 0; m_streak = 0;
          end
        end else if (val == m_exp) begin
          m_streak++;
          if (m_streak == LCNT) begin m_locked = 1; m_streak = 0; end
        end else begin
          m_streak = 0;
        end
        m_exp = (val + 1) % 16;
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("locked",      int'(locked1), int'(m_locked));
      chk("err_pulse",   int'(pulse1),  int'(m_pulse));
      chk("err_cnt",     int'(err1),    sat(m_err, 255));
      chk("good_cnt",    int'(good1),   sat(m_good, 255));
      chk("expected",    int'(exp1),    m_exp);
      chk("locked_w2",   int'(locked2), int'(m_locked));
      chk("err_pulse_w2",int'(pulse2),  int'(m_pulse));
      chk("err_cnt_w2",  int'(err2),    sat(m_err, 3));
      chk("good_cnt_w2", int'(good2),   sat(m_good, 3));
      chk("pulse_back_to_back", int'(pulse1 & prev_pulse), 0);
      if (pulse1) pulses_seen++;
      prev_pulse = pulse1;
    end
  end

  task automatic step(input bit v, input int val, input bit c);
    in_valid = v; in_val = 4'(val); clear = c;
    @(posedge clk);
    model_apply(v, val, c);
    #1;
    in_valid = 1'b0; clear = 1'b0;
  endtask

  task automatic do_reset();
    chk_en = 0;
    in_valid = 1'b0; in_val = 4'd0; clear = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    model_reset();
    prev_pulse = 0;
    pulses_seen = 0;
    chk("rst_locked", int'(locked1), 0);
    chk("rst_pulse",  int'(pulse1),  0);
    chk("rst_err",    int'(err1),    0);
    chk("rst_good",   int'(good1),   0);
    chk("rst_exp",    int'(exp1),    0);
    chk_en = 1;
  endtask

  initial begin
    // Test 1: 20 back-to-back samples with wrap-around.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(1, i % 16, 0);
      if (i == 1) chk("t1_locked_after_2", int'(locked1), 0);
      if (i == 2) chk("t1_locked_after_3", int'(locked1), 1);
    end
    chk("t1_good", int'(good1), 17);
    chk("t1_err",  int'(err1), 0);
    chk("t1_exp",  int'(exp1), 4);
    chk("t1_pulses", pulses_seen, 0);

    // Test 2: mismatch while locked, then relock.
    do_reset();
    step(1, 5, 0); step(1, 6, 0); step(1, 7, 0);
    chk("t2_locked", int'(locked1), 1);
    step(1, 9, 0);
    chk("t2_pulse", int'(pulse1), 1);
    chk("t2_err",   int'(err1), 1);
    chk("t2_unlocked", int'(locked1), 0);
    step(0, 0, 0);
    chk("t2_pulse_gone", int'(pulse1), 0);
    step(1, 10, 0); step(1, 11, 0);
    chk("t2_relocked", int'(locked1), 1);
    chk("t2_exp", int'(exp1), 12);
    chk("t2_pulses", pulses_seen, 1);

    // Test 3: mismatch during SYNC is silent.
    do_reset();
    step(1, 3, 0); step(1, 4, 0); step(1, 4, 0);
    chk("t3_no_pulse", int'(pulse1), 0);
    step(1, 5, 0);
    chk("t3_not_yet", int'(locked1), 0);
    step(1, 6, 0);
    chk("t3_locked", int'(locked1), 1);
    chk("t3_err", int'(err1), 0);

    // Test 4: gaps between samples.
    do_reset();
    step(1, 1, 0);
    repeat (3) step(0, 7, 0);
    step(1, 2, 0);
    repeat (3) step(0, 9, 0);
    chk("t4_hold_exp", int'(exp1), 3);
    step(1, 3, 0);
    chk("t4_locked", int'(locked1), 1);
    chk("t4_good", int'(good1), 0);

    // Test 5: repeated error/relock, saturation of the 2-bit counter.
    do_reset();
    step(1, 0, 0); step(1, 1, 0); step(1, 2, 0);
    for (int k = 0; k < 5; k++) begin
      step(1, (m_exp + 5) % 16, 0);
      step(1, m_exp, 0);
      step(1, m_exp, 0);
    end
    chk("t5_err_w2_sat", int'(err2), 3);
    chk("t5_err_w8", int'(err1), 5);
    chk("t5_pulses", pulses_seen, 5);
    chk("t5_locked", int'(locked2), 1);

    // Test 6: clear with a coincident sample, then asynchronous reset.
    do_reset();
    for (int i = 0; i < 9; i++) step(1, i, 0);
    chk("t6_good6", int'(good1), 6);
    step(1, 9, 1);
    chk("t6_clr_locked", int'(locked1), 0);
    chk("t6_clr_good", int'(good1), 0);
    chk("t6_clr_exp", int'(exp1), 0);
    step(1, 5, 0);
    chk("t6_seed_exp", int'(exp1), 6);
    chk("t6_seed_unlocked", int'(locked1), 0);
    step(1, 6, 0); step(1, 7, 0);
    chk("t6_relocked", int'(locked1), 1);
    chk_en = 0;
    #2 rst = 1'b1;
    #1;
    chk("t6_async_locked", int'(locked1), 0);
    chk("t6_async_exp", int'(exp1), 0);
    @(negedge clk);
    #1 rst = 1'b0;
    model_reset();
    prev_pulse = 0;
    chk_en = 1;
    step(1, 12, 0); step(1, 13, 0); step(1, 14, 0);
    chk("t6_after_rst_locked", int'(locked1), 1);
    step(0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
